countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Single-clock sequencer for the countdown timer datapath: accumulates two-digit keypad entry into `amount`, loads and decrements `remaining` on 1 Hz tick strobes, supports pause/resume, and drives per-digit display enables including an expiry blink. It sits between the keypad decoder and the decimal splitters and display scanner. It uses single-cycle enable strobes instead of derived clocks.

## Interface
- `MAX_VAL`, default 99: entry clamp value; legal range 1..99.
- `EXPIRE_BLINKS`, default 6: number of `blink_en` strobes spent in EXPIRED before auto-rearm; must be ≥1.
- `clk` input 1: system clock (100 MHz); all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `tick_en` input 1: one-cycle strobe at 1 Hz.
- `blink_en` input 1: one-cycle strobe at the blink half-period.
- `keydown_num`, `keydown_start`, `keydown_confirm`, `keydown_clear` input 1 each: one-cycle key pulses, already synchronous to `clk`.
- `num` input 4: digit value, qualified by `keydown_num`.
- `amount` output 7: entered value, 0..MAX_VAL.
- `remaining` output 7: countdown value, 0..MAX_VAL.
- `enable` output 4: digit enables; [3:2] = amount digits, [1:0] = remaining digits.
- `running` output 1: high in RUN.
- `expired` output 1: one-cycle pulse on reaching zero.

## Operation
- Reset values: state IDLE, `amount`=0, `remaining`=0, `enable`=4'b0000, `running`=0, `expired`=0, digit count 0, blink count 0.
- Any `num` > 9 is ignored in every state.
- Key priority when several keys arrive in one cycle: clear > start > confirm > num. Only the highest-priority key acts.
- In any state, clear goes to IDLE and applies the reset values.
- **IDLE**, `enable`=0000.
  - num: `amount`=num, digit count 1, go to ENTRY.
- **ENTRY**, `enable`=1100.
  - num with digit count 1: `amount`=min(amount*10+num, MAX_VAL), digit count 2.
  - num with digit count 2: ignored.
  - confirm with `amount`=0: ignored.
  - confirm with `amount`≠0: `remaining`=`amount`, go to ARMED.
- **ARMED**, `enable`=1111.
  - start: go to RUN.
  - num and confirm: ignored.
- **RUN**, `enable`=1111, `running`=1.
  - `tick_en`: `remaining`-=1.
  - Transition 1→0: go to EXPIRED and pulse `expired`.
  - start: go to PAUSE.
- **PAUSE**, `enable`=1111.
  - `tick_en` is ignored.
  - start: go to RUN.
  - confirm: `remaining`=`amount`, go to ARMED.
- **EXPIRED**, `enable` starts at 1111 and toggles between 1111 and 0000 on each `blink_en`. Blink count increments on each `blink_en`.
  - When blink count reaches EXPIRE_BLINKS: `remaining`=`amount`, `enable`=1111, blink count=0, go to ARMED.
  - start: `remaining`=`amount`, go to RUN.
  - confirm: `remaining`=`amount`, go to ARMED.
- In RUN, a key and `tick_en` in the same cycle: the key transition is taken and the tick is discarded. A clear-only cycle still discards the tick.
- `remaining` never underflows, because the decrement occurs only in RUN with `remaining`≥1.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Key pulse in cycle n produces the new state and outputs in cycle n+1.
- `tick_en` in cycle n (RUN) gives the decremented `remaining` in cycle n+1.
- At the 1→0 tick: `remaining`=0, state EXPIRED and `expired`=1 all appear together in cycle n+1. `expired` is 0 in cycle n+2.
- `blink_en` in cycle n gives the toggled `enable` in cycle n+1.
- Assertion of `rst_n` low mid-operation clears everything immediately (asynchronously). The first key is accepted in the first cycle after deassertion.

## Configuration
- `COUNTDOWN_PAUSE_EN` defined: the PAUSE state exists as described.
- `COUNTDOWN_PAUSE_EN` undefined:
  - PAUSE is not synthesized.
  - start in RUN is ignored.
  - The RUN-state exit set is clear and expiry only.

## Structure
- Shared package `countdown_pkg` holds:
  - state enum `cd_state_t` (IDLE, ENTRY, ARMED, RUN, PAUSE, EXPIRED);
  - enable constants `EN_NONE`=4'b0000, `EN_AMOUNT`=4'b1100, `EN_ALL`=4'b1111;
  - `CD_WIDTH`=7.
- One sub-module is natural: `countdown_entry`, the digit accumulator. It holds `amount`, the digit count, the clamp and the num>9 filter, with load, clear and accept controls from the FSM.

## Test plan
- Reset, then num 4, num 2, confirm → `amount`=42, `remaining`=42, `enable`=1111, state ARMED. A third num 7 in ENTRY leaves `amount`=42.
- MAX_VAL=50: entering 7, 3 → `amount`=50. `num`=12 at any time → no change.
- From ARMED with 3: start, then 3 tick strobes → `remaining` 2, 1, 0. `expired` is high for exactly the cycle after the third tick, and state is EXPIRED.
- EXPIRED with EXPIRE_BLINKS=6: 6 `blink_en` → `enable` alternates 0000/1111 …, then returns to ARMED with `remaining`=`amount` and `enable`=1111.
- RUN at 10: start and `tick_en` in the same cycle → PAUSE with `remaining`=10. Further ticks → no change. Start → RUN. With `COUNTDOWN_PAUSE_EN` undefined → stays RUN and the tick is dropped that cycle.
- RUN: clear and start together → IDLE with all outputs 0. `rst_n` pulsed low mid-RUN → immediate reset values.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer sequencer.
// Optional PAUSE state is controlled by the COUNTDOWN_PAUSE_EN macro.
package countdown_pkg;

  localparam int CD_WIDTH = 7;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    ARMED,
    RUN,
    PAUSE,
    EXPIRED
  } cd_state_t;

  // Decoded key after priority resolution; only one key acts per cycle.
  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_NUM,
    KEY_CONFIRM,
    KEY_START,
    KEY_CLEAR
  } cd_key_t;

  localparam logic [3:0] EN_NONE   = 4'b0000;
  localparam logic [3:0] EN_AMOUNT = 4'b1100;
  localparam logic [3:0] EN_ALL    = 4'b1111;

  function automatic logic [CD_WIDTH-1:0] clamp_amount(input logic [CD_WIDTH:0] value,
                                                       input logic [CD_WIDTH:0] max_val);
    return (value > max_val) ? max_val[CD_WIDTH-1:0] : value[CD_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/countdown_entry.sv
// Two-digit keypad accumulator: filters digits above 9, clamps to MAX_VAL.
module countdown_entry
  import countdown_pkg::*;
#(
  parameter int MAX_VAL = 99
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_num_key,
  input  logic                i_load,
  input  logic                i_accept,
  input  logic [3:0]          i_num,
  output logic                o_num_ok,
  output logic [CD_WIDTH-1:0] o_amount
);

  localparam logic [CD_WIDTH:0] MAX_U = (CD_WIDTH+1)'(MAX_VAL);

  logic [CD_WIDTH-1:0] r_amount;
  logic [1:0]          r_digits;
  logic [CD_WIDTH:0]   w_sum;

  assign o_num_ok = i_num_key && (i_num <= 4'd9);
  assign o_amount = r_amount;
  assign w_sum    = {1'b0, r_amount} * (CD_WIDTH+1)'(10) + (CD_WIDTH+1)'(i_num);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amount <= '0;
      r_digits <= 2'd0;
    end else if (i_clear) begin
      r_amount <= '0;
      r_digits <= 2'd0;
    end else if (o_num_ok && i_load) begin
      r_amount <= clamp_amount((CD_WIDTH+1)'(i_num), MAX_U);
      r_digits <= 2'd1;
    end else if (o_num_ok && i_accept && r_digits == 2'd1) begin
      r_amount <= clamp_amount(w_sum, MAX_U);
      r_digits <= 2'd2;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer sequencer: entry, arm, run, optional pause (COUNTDOWN_PAUSE_EN),
// expiry blink with auto-rearm. All outputs registered.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int MAX_VAL       = 99,
  parameter int EXPIRE_BLINKS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_en,
  input  logic                blink_en,
  input  logic                keydown_num,
  input  logic                keydown_start,
  input  logic                keydown_confirm,
  input  logic                keydown_clear,
  input  logic [3:0]          num,
  output logic [CD_WIDTH-1:0] amount,
  output logic [CD_WIDTH-1:0] remaining,
  output logic [3:0]          enable,
  output logic                running,
  output logic                expired
);

  localparam int BW = (EXPIRE_BLINKS > 1) ? $clog2(EXPIRE_BLINKS + 1) : 1;

  cd_state_t           r_state;
  logic [CD_WIDTH-1:0] r_remaining;
  logic [3:0]          r_enable;
  logic                r_running;
  logic                r_expired;
  logic [BW-1:0]       r_blinks;

  cd_key_t             w_key;
  logic                w_num_ok;
  logic [CD_WIDTH-1:0] w_amount;

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_key = KEY_NONE;
    if (keydown_clear)        w_key = KEY_CLEAR;
    else if (keydown_start)   w_key = KEY_START;
    else if (keydown_confirm) w_key = KEY_CONFIRM;
    else if (w_num_ok)        w_key = KEY_NUM;
  end

  countdown_entry #(.MAX_VAL(MAX_VAL)) u_entry (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_key == KEY_CLEAR),
    .i_num_key (keydown_num),
    .i_load    (r_state == IDLE  && w_key == KEY_NUM),
    .i_accept  (r_state == ENTRY && w_key == KEY_NUM),
    .i_num     (num),
    .o_num_ok  (w_num_ok),
    .o_amount  (w_amount)
  );

  // NOTE: reset covers every control register; the sequencer holds no memory
  // arrays, so nothing here is left deliberately unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_enable    <= EN_NONE;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_blinks    <= '0;
    end else begin
      r_expired <= 1'b0;
      if (w_key == KEY_CLEAR) begin
        r_state     <= IDLE;
        r_remaining <= '0;
        r_enable    <= EN_NONE;
        r_running   <= 1'b0;
        r_blinks    <= '0;
      end else begin
        case (r_state)
          IDLE: if (w_key == KEY_NUM) begin
            r_state  <= ENTRY;
            r_enable <= EN_AMOUNT;
          end
          ENTRY: if (w_key == KEY_CONFIRM && w_amount != '0) begin
            r_remaining <= w_amount;
            r_state     <= ARMED;
            r_enable    <= EN_ALL;
          end
          ARMED: if (w_key == KEY_START) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
          RUN: begin
            // A start key always swallows a same-cycle tick, pause or not.
            if (w_key == KEY_START) begin
`ifdef COUNTDOWN_PAUSE_EN
              r_state   <= PAUSE;
              r_running <= 1'b0;
`endif
            end else if (tick_en && r_remaining != '0) begin
              r_remaining <= r_remaining - CD_WIDTH'(1);
              if (r_remaining == CD_WIDTH'(1)) begin
                r_state   <= EXPIRED;
                r_running <= 1'b0;
                r_expired <= 1'b1;
                r_enable  <= EN_ALL;
                r_blinks  <= '0;
              end
            end
          end
`ifdef COUNTDOWN_PAUSE_EN
          PAUSE: begin
            if (w_key == KEY_START) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end else if (w_key == KEY_CONFIRM) begin
              r_remaining <= w_amount;
              r_state     <= ARMED;
            end
          end
`endif
          EXPIRED: begin
            if (w_key == KEY_START || w_key == KEY_CONFIRM) begin
              r_remaining <= w_amount;
              r_enable    <= EN_ALL;
              r_blinks    <= '0;
              r_state     <= (w_key == KEY_START) ? RUN : ARMED;
              r_running   <= (w_key == KEY_START);
            end else if (blink_en) begin
              if (r_blinks == BW'(EXPIRE_BLINKS - 1)) begin
                r_remaining <= w_amount;
                r_enable    <= EN_ALL;
                r_blinks    <= '0;
                r_state     <= ARMED;
              end else begin
                r_blinks <= r_blinks + BW'(1);
                r_enable <= ~r_enable;
              end
            end
          end
          default: begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_enable    <= EN_NONE;
            r_running   <= 1'b0;
            r_blinks    <= '0;
          end
        endcase
      end
    end
  end

  assign amount    = w_amount;
  assign remaining = r_remaining;
  assign enable    = r_enable;
  assign running   = r_running;
  assign expired   = r_expired;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl; expectations follow COUNTDOWN_PAUSE_EN if defined.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en, blink_en;
  logic       keydown_num, keydown_start, keydown_confirm, keydown_clear;
  logic [3:0] num;

  logic [6:0] amount, remaining, amount50, remaining50;
  logic [3:0] enable, enable50;
  logic       running, expired, running50, expired50;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(.MAX_VAL(99), .EXPIRE_BLINKS(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .blink_en(blink_en),
    .keydown_num(keydown_num), .keydown_start(keydown_start),
    .keydown_confirm(keydown_confirm), .keydown_clear(keydown_clear), .num(num),
    .amount(amount), .remaining(remaining), .enable(enable),
    .running(running), .expired(expired)
  );

  // Second instance shares stimulus to observe the MAX_VAL clamp.
  countdown_ctrl #(.MAX_VAL(50), .EXPIRE_BLINKS(6)) u_dut50 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .blink_en(blink_en),
    .keydown_num(keydown_num), .keydown_start(keydown_start),
    .keydown_confirm(keydown_confirm), .keydown_clear(keydown_clear), .num(num),
    .amount(amount50), .remaining(remaining50), .enable(enable50),
    .running(running50), .expired(expired50)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [6:0] a, input logic [6:0] r,
                            input logic [3:0] e, input logic run, input logic exp);
    check({tag, ".amount"},    32'(amount),    32'(a));
    check({tag, ".remaining"}, 32'(remaining), 32'(r));
    check({tag, ".enable"},    32'(enable),    32'(e));
    check({tag, ".running"},   32'(running),   32'(run));
    check({tag, ".expired"},   32'(expired),   32'(exp));
  endtask

  // One clock with the given strobes; outputs sampled 1 time unit after the edge.
  task automatic step(input logic t, input logic b, input logic s, input logic c,
                      input logic cl, input logic n, input logic [3:0] d);
    tick_en = t; blink_en = b; keydown_start = s; keydown_confirm = c;
    keydown_clear = cl; keydown_num = n; num = d;
    @(posedge clk);
    #1;
    tick_en = 0; blink_en = 0; keydown_start = 0; keydown_confirm = 0;
    keydown_clear = 0; keydown_num = 0; num = 4'd0;
  endtask

  task automatic press_num(input logic [3:0] d); step(0, 0, 0, 0, 0, 1, d); endtask
  task automatic press_confirm();                step(0, 0, 0, 1, 0, 0, 4'd0); endtask
  task automatic press_start();                  step(0, 0, 1, 0, 0, 0, 4'd0); endtask
  task automatic press_clear();                  step(0, 0, 0, 0, 1, 0, 4'd0); endtask
  task automatic do_tick();                      step(1, 0, 0, 0, 0, 0, 4'd0); endtask
  task automatic do_blink();                     step(0, 1, 0, 0, 0, 0, 4'd0); endtask
  task automatic idle_cycle();                   step(0, 0, 0, 0, 0, 0, 4'd0); endtask

  initial begin
    logic paused;
`ifdef COUNTDOWN_PAUSE_EN
    paused = 1'b1;
`else
    paused = 1'b0;
`endif
    rst_n = 1'b0;
    tick_en = 0; blink_en = 0; keydown_num = 0; keydown_start = 0;
    keydown_confirm = 0; keydown_clear = 0; num = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Basic entry and arm
    press_num(4'd4);
    expect_out("entry_4", 7'd4, 7'd0, 4'b1100, 1'b0, 1'b0);
    press_num(4'd2);
    expect_out("entry_42", 7'd42, 7'd0, 4'b1100, 1'b0, 1'b0);
    press_num(4'd7);
    check("third_digit", 32'(amount), 32'd42);
    press_confirm();
    expect_out("armed_42", 7'd42, 7'd42, 4'b1111, 1'b0, 1'b0);

    // Digit filter and clamp
    press_clear();
    expect_out("clear_armed", 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0);
    press_num(4'd12);
    expect_out("idle_num12", 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0);
    press_num(4'd7);
    press_num(4'd12);
    check("entry_num12", 32'(amount), 32'd7);
    press_num(4'd3);
    check("entry_73", 32'(amount), 32'd73);
    check("clamp_50", 32'(amount50), 32'd50);

    // Countdown to expiry
    press_clear();
    press_num(4'd3);
    press_confirm();
    expect_out("armed_3", 7'd3, 7'd3, 4'b1111, 1'b0, 1'b0);
    press_start();
    expect_out("run_3", 7'd3, 7'd3, 4'b1111, 1'b1, 1'b0);
    do_tick();
    expect_out("tick_2", 7'd3, 7'd2, 4'b1111, 1'b1, 1'b0);
    do_tick();
    expect_out("tick_1", 7'd3, 7'd1, 4'b1111, 1'b1, 1'b0);
    do_tick();
    expect_out("tick_0", 7'd3, 7'd0, 4'b1111, 1'b0, 1'b1);
    idle_cycle();
    expect_out("expired_hold", 7'd3, 7'd0, 4'b1111, 1'b0, 1'b0);

    // Expiry blink and auto-rearm
    do_blink(); check("blink1", 32'(enable), 32'h0);
    do_blink(); check("blink2", 32'(enable), 32'hF);
    do_blink(); check("blink3", 32'(enable), 32'h0);
    do_blink(); check("blink4", 32'(enable), 32'hF);
    do_blink(); check("blink5", 32'(enable), 32'h0);
    do_blink();
    expect_out("rearm", 7'd3, 7'd3, 4'b1111, 1'b0, 1'b0);
    press_start();
    check("rearm_start", 32'(running), 32'd1);

    // Start and tick colliding in RUN
    press_clear();
    press_num(4'd1);
    press_num(4'd0);
    press_confirm();
    press_start();
    expect_out("run_10", 7'd10, 7'd10, 4'b1111, 1'b1, 1'b0);
    step(1, 0, 1, 0, 0, 0, 4'd0);
    check("start_tick.rem", 32'(remaining), 32'd10);
    check("start_tick.run", 32'(running), paused ? 32'd0 : 32'd1);
    do_tick();
    check("after_collide_tick", 32'(remaining), paused ? 32'd10 : 32'd9);
    press_start();
    check("resume.run", 32'(running), 32'd1);
    do_tick();
    check("resume_tick", 32'(remaining), paused ? 32'd9 : 32'd8);

    // Clear beats start and the tick
    step(1, 0, 1, 0, 1, 0, 4'd0);
    expect_out("clear_start", 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset mid-run
    press_num(4'd5);
    press_confirm();
    press_start();
    do_tick();
    expect_out("run_5_tick", 7'd5, 7'd4, 4'b1111, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    press_num(4'd8);
    expect_out("post_reset_key", 7'd8, 7'd0, 4'b1100, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
